// File: rtl/min_select_stream.sv
// Streaming arg-min / arg-max selector: scans N candidate beats per frame and
// reports the winning candidate's distance, payload, coordinates and position.
module min_select_stream #(
    parameter int N  = 8,
    parameter int DW = 11,
    parameter int WW = 24,
    parameter int CW = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_dist,
    input  logic [WW-1:0] in_weight,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] X_c,
    output logic [CW-1:0] Y_c,
    output logic [WW-1:0] weight_c,
    output logic [DW-1:0] dist_c,
    output logic [PW-1:0] pos_c
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic [PW:0] N_L = N[PW:0];

    state_t        state, state_nxt;
    logic [PW:0]   cnt, cnt_inc;
    logic          mode_l;
    logic [DW-1:0] best_dist, nb_dist;
    logic [WW-1:0] best_weight, nb_weight;
    logic [CW-1:0] best_x, best_y, nb_x, nb_y;
    logic [PW-1:0] best_pos, nb_pos;
    logic          accept, last, replace, take;

    // Candidate best after the current beat; also what gets published on the last beat.
    always_comb begin
        accept    = in_valid && in_ready;
        cnt_inc   = cnt + 1'b1;
        last      = accept && (cnt_inc == N_L);
        replace   = mode_l ? (in_dist > best_dist) : (in_dist < best_dist);
        take      = (state == IDLE) || replace;
        nb_dist   = take ? in_dist   : best_dist;
        nb_weight = take ? in_weight : best_weight;
        nb_x      = take ? in_x      : best_x;
        nb_y      = take ? in_y      : best_y;
        nb_pos    = (state == IDLE) ? '0 : (replace ? cnt[PW-1:0] : best_pos);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = last ? OUT : ACC;
            ACC:     if (last) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != OUT);
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            mode_l      <= 1'b0;
            best_dist   <= '0;
            best_weight <= '0;
            best_x      <= '0;
            best_y      <= '0;
            best_pos    <= '0;
            X_c         <= '0;
            Y_c         <= '0;
            weight_c    <= '0;
            dist_c      <= '0;
            pos_c       <= '0;
        end else begin
            if (accept) begin
                cnt         <= cnt_inc;
                best_dist   <= nb_dist;
                best_weight <= nb_weight;
                best_x      <= nb_x;
                best_y      <= nb_y;
                best_pos    <= nb_pos;
                if (state == IDLE) mode_l <= mode;
            end
            if (last) begin
                X_c      <= nb_x;
                Y_c      <= nb_y;
                weight_c <= nb_weight;
                dist_c   <= nb_dist;
                pos_c    <= nb_pos;
            end
            if (state == OUT && out_ready) cnt <= '0;
        end
    end

endmodule

// File: tb/tb_min_select_stream.sv
// Directed bench for min_select_stream: table of 8-beat frames plus hand-written
// backpressure, asynchronous reset and N=1 sequences.
module tb_min_select_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [10:0] in_dist = '0;
    logic [23:0] in_weight = '0;
    logic [2:0]  in_x = '0, in_y = '0;
    logic        in_ready, out_valid;
    logic [2:0]  X_c, Y_c;
    logic [23:0] weight_c;
    logic [10:0] dist_c;
    logic [2:0]  pos_c;

    logic        u1_in_valid = 1'b0, u1_out_ready = 1'b1;
    logic [10:0] u1_in_dist = '0;
    logic        u1_in_ready, u1_out_valid;
    logic [2:0]  u1_X_c, u1_Y_c;
    logic [23:0] u1_weight_c;
    logic [10:0] u1_dist_c;
    logic [0:0]  u1_pos_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    min_select_stream dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_dist(in_dist), .in_weight(in_weight), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .X_c(X_c), .Y_c(Y_c),
        .weight_c(weight_c), .dist_c(dist_c), .pos_c(pos_c)
    );

    min_select_stream #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .mode(1'b0), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .in_dist(u1_in_dist), .in_weight(24'h000055), .in_x(3'd3), .in_y(3'd4),
        .out_valid(u1_out_valid), .out_ready(u1_out_ready), .X_c(u1_X_c), .Y_c(u1_Y_c),
        .weight_c(u1_weight_c), .dist_c(u1_dist_c), .pos_c(u1_pos_c)
    );

    typedef struct {
        logic             mode;
        logic             gap;
        logic [0:7][10:0] d;
        logic [10:0]      exp_dist;
        int               exp_pos;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic m, input logic g,
                                input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int ed, input int ep);
        vec_t v;
        v.mode = m;
        v.gap  = g;
        v.d    = {11'(a0), 11'(a1), 11'(a2), 11'(a3), 11'(a4), 11'(a5), 11'(a6), 11'(a7)};
        v.exp_dist = 11'(ed);
        v.exp_pos  = ep;
        return v;
    endfunction

    // Payload carried by the beat at position k of every frame.
    function automatic logic [23:0] wt(input int k);
        return (k == 1) ? 24'hABCDEF : 24'h100000 + 24'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int k, input logic [10:0] d);
        in_valid  = 1'b1;
        in_dist   = d;
        in_x      = 3'(k);
        in_y      = 3'(k + 1);
        in_weight = wt(k);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        for (int k = 0; k < 8; k++) begin
            if (v.gap && k > 0) begin
                in_valid = 1'b0;
                step();
                step();
            end
            drive_beat(k, v.d[k]);
            mode = (k == 0) ? v.mode : ~v.mode;
            if (k == 7) chk({tag, " out_valid_before_last"}, {31'd0, out_valid}, 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, " in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, " dist_c"},    {21'd0, dist_c},    {21'd0, v.exp_dist});
        chk({tag, " pos_c"},     {29'd0, pos_c},     32'(v.exp_pos));
        chk({tag, " X_c"},       {29'd0, X_c},       32'(v.exp_pos & 7));
        chk({tag, " Y_c"},       {29'd0, Y_c},       32'((v.exp_pos + 1) & 7));
        chk({tag, " weight_c"},  {8'd0, weight_c},   {8'd0, wt(v.exp_pos)});
    endtask

    task automatic release_result(input string tag, input logic [10:0] exp_dist);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " out_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " dist_c_persists"},    {21'd0, dist_c},    {21'd0, exp_dist});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk(0, 0, 9, 4, 7, 4, 12, 6, 5, 8,           4,    1);
        vecs[1] = mk(1, 0, 3, 2047, 5, 2047, 0, 1, 2, 3,       2047, 1);
        vecs[2] = mk(0, 1, 9, 4, 7, 4, 12, 6, 5, 8,           4,    1);
        vecs[3] = mk(0, 0, 5, 5, 5, 5, 5, 5, 5, 5,            5,    0);
        vecs[4] = mk(0, 0, 3, 3, 0, 7, 0, 1, 2, 0,            0,    2);
        vecs[5] = mk(1, 0, 100, 100, 100, 100, 100, 100, 100, 100, 100, 0);
        vecs[6] = mk(1, 0, 1, 2, 3, 4, 5, 6, 7, 8,            8,    7);
        vecs[7] = mk(0, 0, 8, 7, 6, 5, 4, 3, 2, 1,            1,    7);
        vecs[8] = mk(0, 0, 1, 2000, 2047, 1024, 2, 3, 1, 9,   1,    0);
        vecs[9] = mk(1, 1, 1023, 1024, 1023, 1025, 7, 1025, 0, 1024, 1025, 3);

        #2;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset dist_c",    {21'd0, dist_c},    32'd0);
        chk("reset weight_c",  {8'd0, weight_c},   32'd0);
        chk("reset pos_c",     {29'd0, pos_c},     32'd0);
        chk("reset n1 out_valid", {31'd0, u1_out_valid}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i), vecs[i].exp_dist);
        end

        // Backpressure: result held while a beat is offered and refused.
        run_frame(vecs[1], "bp_frame");
        drive_beat(0, 11'd0);
        mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp dist_c",    {21'd0, dist_c},    32'd2047);
            chk("bp pos_c",     {29'd0, pos_c},     32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        run_frame(vecs[0], "bp_next");
        release_result("bp_next", 11'd4);

        // Asynchronous reset between edges after beat 5 of a frame.
        mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_beat(k, 11'd0);
            step();
        end
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst dist_c",    {21'd0, dist_c},    32'd0);
        chk("arst X_c",       {29'd0, X_c},       32'd0);
        chk("arst Y_c",       {29'd0, Y_c},       32'd0);
        chk("arst weight_c",  {8'd0, weight_c},   32'd0);
        chk("arst pos_c",     {29'd0, pos_c},     32'd0);
        #2;
        rst = 1'b0;
        step();
        chk("arst in_ready", {31'd0, in_ready}, 32'd1);
        run_frame(vecs[0], "arst_next");
        release_result("arst_next", 11'd4);

        // N=1: continuous beats with out_ready=1 give a result every 2 clocks.
        u1_out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            u1_in_valid = 1'b1;
            u1_in_dist  = 11'(50 + 7 * r);
            step();
            chk("n1 out_valid", {31'd0, u1_out_valid}, 32'd1);
            chk("n1 in_ready",  {31'd0, u1_in_ready},  32'd0);
            chk("n1 dist_c",    {21'd0, u1_dist_c},    32'(50 + 7 * r));
            chk("n1 pos_c",     {31'd0, u1_pos_c},     32'd0);
            chk("n1 X_c",       {29'd0, u1_X_c},       32'd3);
            u1_in_dist = 11'd999;
            step();
            chk("n1 out_valid_low", {31'd0, u1_out_valid}, 32'd0);
            chk("n1 in_ready_hi",   {31'd0, u1_in_ready},  32'd1);
        end
        u1_in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/min_select_stream.md
MIN_SELECT_STREAM -- requirements
Module: min_select_stream

Interface
REQ-001 Parameter N, default 8: candidates per frame; legal range 1..256.
REQ-002 Parameter DW, default 11: distance width, unsigned.
REQ-003 Parameter WW, default 24: weight width, opaque payload.
REQ-004 Parameter CW, default 3: coordinate width, per axis.
REQ-005 PW = max(1, clog2(N)): position width, derived, not overridable.
REQ-006 Clocking SHALL be one clock, clk; reset SHALL be rst, asynchronous, active-high.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 mode  input  1  0 = select minimum, 1 = select maximum; sampled on first beat of a frame only.
REQ-010 in_valid  input  1  candidate beat valid.
REQ-011 in_ready  output  1  block accepts a beat.
REQ-012 in_dist  input  DW  candidate distance.
REQ-013 in_weight  input  WW  candidate weight.
REQ-014 in_x  input  CW  candidate X coordinate.
REQ-015 in_y  input  CW  candidate Y coordinate.
REQ-016 out_valid  output  1  result valid.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 X_c  output  CW  winning X.
REQ-019 Y_c  output  CW  winning Y.
REQ-020 weight_c  output  WW  winning weight.
REQ-021 dist_c  output  DW  winning distance.
REQ-022 pos_c  output  PW  arrival position (0..N-1) of the winner within its frame.

Function
REQ-023 States SHALL be IDLE, ACC and OUT; in_ready SHALL be 1 in IDLE and ACC and 0 in OUT.
REQ-024 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-025 Beat counter cnt (PW+1 bits) SHALL count accepted beats in the frame.
- clears on entry to IDLE
- never exceeds N
REQ-026 IDLE, accepted beat: load the best registers unconditionally.
- best = {dist, weight, x, y}, pos = 0
- latch mode
- cnt = 1
- go to ACC, or to OUT when N = 1
REQ-027 ACC, accepted beat at position k: replace best and set pos = k only when the replace test holds; otherwise keep best.
- mode 0: in_dist < best_dist
- mode 1: in_dist > best_dist
REQ-028 Ties SHALL keep the earlier candidate (strict compare); the comparison SHALL be unsigned, full DW width.
REQ-029 The transition to OUT SHALL occur on acceptance of the Nth beat.
- out_valid rises on the next cycle (latency 1 clock from the last beat)
- result includes the Nth beat
REQ-030 OUT: outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 On out_valid & out_ready, go to IDLE with out_valid=0 the next cycle; the next frame may start that cycle.
REQ-032 in_valid while in_ready=0 SHALL be ignored and not counted.
- The source holds the beat.
REQ-033 Gaps (in_valid=0) in ACC SHALL stall without losing state.
REQ-034 Output registers X_c, Y_c, weight_c, dist_c and pos_c SHALL update only on the ACC/IDLE-to-OUT transition.
- Values persist after the handshake until the next frame result.
REQ-035 A mode change mid-frame SHALL have no effect until the next frame's first beat.
REQ-036 A frame of identical distances SHALL report pos_c = 0.
- mode 0: a frame that includes 0 reports dist_c = 0.
- mode 1: a frame that includes 2^DW-1 reports dist_c = 2^DW-1.

Reset
REQ-037 rst=1 SHALL immediately set the following, independent of clk:
- state = IDLE, cnt = 0
- out_valid = 0
- X_c, Y_c, weight_c, dist_c, pos_c = 0
- best registers = 0, latched mode = 0
REQ-038 Reset mid-frame or in OUT SHALL discard the partial frame or pending result; in_ready=1 from the first clock after rst falls.

Verification
REQ-039 Min frame, N=8, mode 0, back-to-back beats.
- Stimulus: dists 9,4,7,4,12,6,5,8; beat 1 has x=1, y=2, weight=0xABCDEF.
- Response: dist_c=4, pos_c=1, X_c=1, Y_c=2, weight_c=0xABCDEF; out_valid exactly 1 clock after beat 8.
REQ-040 Max frame, N=8, mode 1.
- Stimulus: dists 3,2047,5,2047,0,1,2,3.
- Response: dist_c=2047, pos_c=1 (tie keeps earlier); mode toggled after beat 1 has no effect.
REQ-041 Backpressure.
- Stimulus: out_ready=0 for 5 cycles, in_valid held 1.
- Response: outputs stable, in_ready=0, no beats counted; after out_ready=1, next frame accepted on the following cycle.
REQ-042 Gapped input: in_valid toggles 1,0,0,1,... across 8 beats.
- Response: same result as the gapless frame; out_valid 1 clock after the 8th accepted beat.
REQ-043 Asynchronous reset asserted after beat 5, between clock edges.
- Response: out_valid=0 and all outputs 0 immediately; the new 8-beat frame after release yields the correct result with no carryover.
REQ-044 N=1 build.
- Every beat produces a result 1 clock later with pos_c=0; continuous in_valid with out_ready=1 gives one result every 2 clocks.
